// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_ctrl_state_t;

  localparam int PIPE_DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/lu_detect.sv
// Combinational load-use compare between the ID sources and the EX load destination.
// Kept standalone so the forwarding unit can share the same compare.
module lu_detect #(
  parameter int ADDR_LEFT = 4
) (
  input  logic               valid_s2,
  input  logic [ADDR_LEFT:0] rs_addr_s2,
  input  logic [ADDR_LEFT:0] rt_addr_s2,
  input  logic               use_rs_s2,
  input  logic               use_rt_s2,
  input  logic               sel_mem_s3,
  input  logic               rw_s3,
  input  logic [ADDR_LEFT:0] waddr_s3,
  output logic               lu_hit
);

  logic rs_match;
  logic rt_match;

  assign rs_match = use_rs_s2 & (rs_addr_s2 == waddr_s3);
  assign rt_match = use_rt_s2 & (rt_addr_s2 == waddr_s3);

  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign lu_hit = valid_s2 & sel_mem_s3 & ~rw_s3 & (waddr_s3 != '0) & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / halt sequencing controller (load-use, memory wait, branch, drain).
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_WORDS    = 32,
  parameter int ADDR_LEFT    = $clog2(REG_WORDS) - 1,
  parameter int DRAIN_CYCLES = PIPE_DRAIN_CYCLES_DEFAULT,
  parameter int CNT_BITS     = 32
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                valid_s2,
  input  logic [ADDR_LEFT:0]  rs_addr_s2,
  input  logic [ADDR_LEFT:0]  rt_addr_s2,
  input  logic                use_rs_s2,
  input  logic                use_rt_s2,
  input  logic                halt_s2,
  input  logic                sel_mem_s3,
  input  logic                rw_s3,
  input  logic [ADDR_LEFT:0]  waddr_s3,
  input  logic                take_branch_s3,
  input  logic                mem_req_s4,
  input  logic                mem_ready,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_s3,
  output logic                flush_s2,
  output logic                stall_mem,
  output logic                halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] flush_cnt
`endif
);

  pipe_ctrl_state_t state, state_nxt, eff_state;
  logic             ret_drain, ret_drain_nxt;
  logic [2:0]       drain_cnt, drain_cnt_nxt;
  logic             lu_hit;
  logic             mem_wait;

  lu_detect #(.ADDR_LEFT(ADDR_LEFT)) u_lu_detect (
    .valid_s2   (valid_s2),
    .rs_addr_s2 (rs_addr_s2),
    .rt_addr_s2 (rt_addr_s2),
    .use_rs_s2  (use_rs_s2),
    .use_rt_s2  (use_rt_s2),
    .sel_mem_s3 (sel_mem_s3),
    .rw_s3      (rw_s3),
    .waddr_s3   (waddr_s3),
    .lu_hit     (lu_hit)
  );

  assign mem_wait = mem_req_s4 & ~mem_ready;

  // Once memory completes, MEM_WAIT behaves exactly like the state it interrupted,
  // so a pending load-use stall or drain step resumes in that same cycle.
  assign eff_state = (state == MEM_WAIT) ? (ret_drain ? DRAIN : RUN) : state;

  // NOTE: every output and next-state variable gets a default first so no path infers a latch.
  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    bubble_s3     = 1'b0;
    flush_s2      = 1'b0;
    stall_mem     = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    ret_drain_nxt = ret_drain;
    drain_cnt_nxt = drain_cnt;

    if (eff_state == HALTED) begin
      halted    = 1'b1;
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_mem = 1'b1;
      bubble_s3 = 1'b1;
    end else if (mem_wait) begin
      stall_if      = 1'b1;
      stall_id      = 1'b1;
      stall_mem     = 1'b1;
      state_nxt     = MEM_WAIT;
      ret_drain_nxt = (eff_state == DRAIN);
    end else if (eff_state == DRAIN) begin
      // Branches are ignored here: halt is older than anything still in EX.
      stall_if  = 1'b1;
      flush_s2  = 1'b1;
      state_nxt = DRAIN;
      if (drain_cnt <= 3'd1) begin
        state_nxt     = HALTED;
        drain_cnt_nxt = 3'd0;
      end else begin
        drain_cnt_nxt = drain_cnt - 3'd1;
      end
    end else begin
      state_nxt = RUN;
      if (take_branch_s3) begin
        flush_s2  = 1'b1;
        bubble_s3 = 1'b1;
      end else if (lu_hit) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_s3 = 1'b1;
      end else if (halt_s2 && valid_s2) begin
        bubble_s3     = 1'b1;
        state_nxt     = DRAIN;
        drain_cnt_nxt = 3'(DRAIN_CYCLES);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state     <= RUN;
      ret_drain <= 1'b0;
      drain_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      ret_drain <= ret_drain_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && (state != HALTED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_BITS'(1);
      if (flush_s2 && (eff_state == RUN) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_BITS'(1);
    end
  end
`endif

endmodule
